seri2para: RTL and testbench

SERI2PARA -- requirements
Module: seri2para

---
 rtl/seri2para.sv | 104 ++++++++++
 tb/tb_seri2para.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seri2para.sv
// Serial-to-parallel packer: collects IN_WIDTH-bit words into groups of up to
// OUT_NUM words, closing early on in_last, and presents each group as one wide word.
module seri2para #(
    parameter int OUT_NUM  = 8,
    parameter int IN_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_WIDTH-1:0]             in,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [IN_WIDTH*OUT_NUM-1:0]     out,
    output logic [$clog2(OUT_NUM+1)-1:0]    out_cnt
);

    localparam int CNT_W  = $clog2(OUT_NUM);
    localparam int OCNT_W = $clog2(OUT_NUM + 1);
    localparam int BUF_W  = IN_WIDTH * OUT_NUM;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_NUM - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [BUF_W-1:0]  out_q, out_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;

    logic             in_fire;
    logic             out_fire;
    logic             close;
    logic [BUF_W-1:0] merged;

    // Input is blocked only while a completed word sits unaccepted downstream.
    assign in_ready = !(out_valid_q && !out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign close    = in_fire && ((cnt_q == LAST_IDX) || in_last);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        merged = buf_q;
        for (int k = 0; k < OUT_NUM; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                merged[k*IN_WIDTH +: IN_WIDTH] = in;
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_d       = out_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        if (in_fire) begin
            if (close) begin
                // Buffer is zeroed on close so the slots a short group leaves
                // unfilled read as zero in the next output.
                cnt_d     = '0;
                buf_d     = '0;
                out_d     = merged;
                out_cnt_d = OCNT_W'(cnt_q) + OCNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                buf_d = merged;
            end
        end

        if (close) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the data registers are reset as well, not just the control bits;
    // the short-group zero fill depends on the collect buffer starting at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            buf_q       <= '0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_seri2para.sv
// Scoreboard bench for seri2para: a group model pushes expected outputs as words
// are accepted; a negedge monitor records every output transfer for comparison.
module tb_seri2para;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [N*W-1:0] data;
        logic [CW-1:0]  cnt;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [CW-1:0]  out_cnt;

    beat_t exp_q[$];
    beat_t obs_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt = 0;

    logic [N*W-1:0] m_buf;
    int             m_cnt;

    seri2para #(.OUT_NUM(N), .IN_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_data),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so at negedge they are stable and a
    // transfer seen here happens on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back({out_data, out_cnt});
        if (!rst && in_valid && !in_ready) stall_cnt++;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_buf = '0;
        m_cnt = 0;
    endtask

    // Offer one word (call at posedge+1); returns at posedge+1 after acceptance.
    task automatic send(input logic [W-1:0] data, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            sync();
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: word %h not accepted within 100 cycles", data);
        end else begin
            m_buf[m_cnt*W +: W] = data;
            if (last || m_cnt == N - 1) begin
                exp_q.push_back({m_buf, CW'(m_cnt + 1)});
                model_clear();
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = $urandom_range(0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) sync();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", out_data); end
        n_cmp++;
        if (out_cnt !== '0) begin n_err++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_group();
        beat_t e, o;
        logic [N*W-1:0] ref_word;
        int t;
        for (int k = 0; k < N; k++) ref_word[k*W +: W] = W'(k);
        sync();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(W'(k), 1'b0);
        idle();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency: out_valid got %b want 1", out_valid); end
        n_cmp++;
        if (out_data !== ref_word) begin n_err++; $display("FAIL full_data: got %h want %h", out_data, ref_word); end
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL full_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL full_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_short_group();
        beat_t e, o;
        logic [N*W-1:0] ref_word;
        int t;
        ref_word = '0;
        ref_word[0*W +: W] = 32'hA;
        ref_word[1*W +: W] = 32'hB;
        ref_word[2*W +: W] = 32'hC;
        sync();
        out_ready = 1'b1;
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b1);
        idle();
        n_cmp++;
        if (out_data !== ref_word || out_cnt !== CW'(3)) begin
            n_err++; $display("FAIL short_data: got %h/%0d want %h/3", out_data, out_cnt, ref_word);
        end
        // Following group must start again at slot 0 with no leftovers.
        for (int k = 0; k < 5; k++) send(32'h100 + W'(k), k == 4);
        send(32'hFEED, 1'b1);
        idle();
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL short_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL short_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        beat_t e, o;
        logic [N*W-1:0] snap;
        logic [CW-1:0]  snap_cnt;
        int t;
        sync();
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) send(32'h2000 + W'(k), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h3000;
        in_last  = 1'b0;
        @(negedge clk);
        snap = out_data;
        snap_cnt = out_cnt;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            n_cmp++;
            if (out_data !== snap || out_cnt !== snap_cnt || out_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_hold: got %h/%0d v=%b want %h/%0d v=1", out_data, out_cnt, out_valid, snap, snap_cnt);
            end
            @(negedge clk);
        end
        sync();
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: in_ready got %b want 1", in_ready); end
        for (int k = 0; k < N; k++) send(32'h3000 + W'(k), 1'b0);
        idle();
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL stall_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL stall_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        beat_t e, o;
        int t;
        sync();
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int k = 0; k < 4 * N; k++) send($urandom, 1'b0);
        idle();
        n_cmp++;
        if (stall_cnt != 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stall_cnt); end
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d outputs want 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL b2b_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_close_and_drain();
        beat_t e, o;
        logic [N*W-1:0] ref_word;
        int t;
        sync();
        out_ready = 1'b0;
        send(32'h51, 1'b0);
        send(32'h52, 1'b1);
        // Offer a one-word group and release out_ready on the same edge.
        in_valid  = 1'b1;
        in_data   = 32'h77;
        in_last   = 1'b1;
        out_ready = 1'b1;
        send(32'h77, 1'b1);
        idle();
        ref_word = '0;
        ref_word[W-1:0] = 32'h77;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ref_word || out_cnt !== CW'(1)) begin
            n_err++; $display("FAIL same_edge: got v=%b %h/%0d want v=1 %h/1", out_valid, out_data, out_cnt, ref_word);
        end
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL same_edge_count: got %0d outputs want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL same_edge_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        int t;
        sync();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(32'hDEAD0 + W'(k), 1'b0);
        idle();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_cnt !== '0) begin
            n_err++; $display("FAIL mid_reset_state: got v=%b cnt=%0d want v=0 cnt=0", out_valid, out_cnt);
        end
        sync();
        for (int k = 0; k < N; k++) send(32'h600 + W'(k), 1'b0);
        idle();
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL mid_reset_count: got %0d outputs want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL mid_reset_sb: got %h/%0d want %h/%0d", o.data, o.cnt, e.data, e.cnt); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_short_group();
        test_stall();
        test_back_to_back();
        test_close_and_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
